// File: rtl/bram_acc_engine.sv
// Streaming multi-lane accumulator: reads rows from BRAM0, accumulates each lane
// independently (wrap or saturate), and writes running or final sums to BRAM1.
module bram_acc_engine #(
  parameter int NUM_LANE  = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int AWIDTH    = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start_run_i,
  input  logic [CNT_WIDTH-1:0]          run_count_i,
  input  logic [AWIDTH-1:0]             src_base_i,
  input  logic [AWIDTH-1:0]             dst_base_i,
  input  logic                          mode_i,
  input  logic                          sat_i,
  input  logic [NUM_LANE*IN_WIDTH-1:0]  q_b0_i,
  output logic                          idle_o,
  output logic                          read_o,
  output logic                          write_o,
  output logic                          done_o,
  output logic [AWIDTH-1:0]             addr_b0_o,
  output logic                          ce_b0_o,
  output logic                          we_b0_o,
  output logic [NUM_LANE*IN_WIDTH-1:0]  d_b0_o,
  output logic [AWIDTH-1:0]             addr_b1_o,
  output logic                          ce_b1_o,
  output logic                          we_b1_o,
  output logic [NUM_LANE*ACC_WIDTH-1:0] d_b1_o
);

  localparam int DWIDTH_IN  = NUM_LANE * IN_WIDTH;
  localparam int DWIDTH_OUT = NUM_LANE * ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   drain_q, drain_d;
  logic [CNT_WIDTH-1:0]   run_cnt_q;
  logic [AWIDTH-1:0]      src_q, dst_q;
  logic                   mode_q, sat_q;
  logic                   start_accept;
  logic                   rd_issue;
  logic                   rd_is_last;

  // Read/accumulate/write pipeline: rd_* tracks the cycle q_b0_i is valid,
  // wr_* tracks the cycle the updated accumulator is visible.
  logic                   rd_v_q, rd_last_q, wr_v_q, wr_last_q;
  logic [CNT_WIDTH-1:0]   rd_k_q, wr_k_q;
  logic [ACC_WIDTH-1:0]   acc_q [NUM_LANE];
  logic [ACC_WIDTH-1:0]   acc_d [NUM_LANE];
  logic                   wr_en;

  assign rd_is_last = (cnt_q == run_cnt_q - CNT_WIDTH'(1));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    start_accept = 1'b0;
    rd_issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_run_i) begin
          start_accept = 1'b1;
          cnt_d        = '0;
          drain_d      = 1'b0;
          state_d      = (run_count_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        rd_issue = 1'b1;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        if (rd_is_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      logic [ACC_WIDTH:0] sum;
      sum = {1'b0, acc_q[i]}
          + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, q_b0_i[IN_WIDTH*i +: IN_WIDTH]};
      acc_d[i] = (sat_q && sum[ACC_WIDTH]) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      run_cnt_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      mode_q    <= 1'b0;
      sat_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_last_q <= 1'b0;
      rd_k_q    <= '0;
      wr_v_q    <= 1'b0;
      wr_last_q <= 1'b0;
      wr_k_q    <= '0;
      for (int i = 0; i < NUM_LANE; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      rd_v_q    <= rd_issue;
      rd_last_q <= rd_issue && rd_is_last;
      rd_k_q    <= cnt_q;
      wr_v_q    <= rd_v_q;
      wr_last_q <= rd_last_q;
      wr_k_q    <= rd_k_q;
      if (start_accept) begin
        run_cnt_q <= run_count_i;
        src_q     <= src_base_i;
        dst_q     <= dst_base_i;
        mode_q    <= mode_i;
        sat_q     <= sat_i;
        for (int i = 0; i < NUM_LANE; i++) acc_q[i] <= '0;
      end else if (rd_v_q) begin
        for (int i = 0; i < NUM_LANE; i++) acc_q[i] <= acc_d[i];
      end
    end
  end

  // Total mode writes only the row flagged last, always at the base address.
  assign wr_en = wr_v_q && (!mode_q || wr_last_q);

  always_comb begin
    d_b1_o = '0;
    for (int i = 0; i < NUM_LANE; i++)
      if (wr_en) d_b1_o[ACC_WIDTH*i +: ACC_WIDTH] = acc_q[i];
  end

  assign addr_b1_o = !wr_en ? '0 : (mode_q ? dst_q : dst_q + AWIDTH'(wr_k_q));
  assign addr_b0_o = rd_issue ? src_q + AWIDTH'(cnt_q) : '0;
  assign ce_b0_o   = rd_issue;
  assign read_o    = rd_issue;
  assign ce_b1_o   = wr_en;
  assign we_b1_o   = wr_en;
  assign write_o   = wr_en;
  assign we_b0_o   = 1'b0;
  assign d_b0_o    = {DWIDTH_IN{1'b0}};
  assign idle_o    = (state_q == S_IDLE);
  assign done_o    = (state_q == S_DONE);

  // Keeps the derived output width visible alongside the port declaration.
  if (DWIDTH_OUT != NUM_LANE * ACC_WIDTH) begin : g_width_guard
    $error("DWIDTH_OUT inconsistent");
  end

endmodule

// File: tb/tb_bram_acc_engine.sv
// Directed bench for bram_acc_engine: cycle-accurate timeline checks plus
// hand-computed write data for prefix, total, wrap, saturation and restart cases.
module tb_bram_acc_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_run_i;
  logic [7:0]  run_count_i, src_base_i, dst_base_i;
  logic        mode_i, sat_i;

  logic [31:0] mem [256];
  logic [31:0] q_a, q_s;

  logic        idle_a, read_a, write_a, done_a, ce0_a, we0_a, ce1_a, we1_a;
  logic [7:0]  addr0_a, addr1_a;
  logic [31:0] d0_a;
  logic [63:0] d1_a;

  logic        idle_s, read_s, write_s, done_s, ce0_s, we0_s, ce1_s, we1_s;
  logic [7:0]  addr0_s, addr1_s;
  logic [31:0] d0_s;
  logic [31:0] d1_s;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rd_log[$];
  logic [7:0]  wr_a_log[$];
  logic [63:0] wr_d_log[$];
  logic [31:0] wr_s_log[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce0_a) q_a <= mem[addr0_a];
    if (ce0_s) q_s <= mem[addr0_s];
  end

  bram_acc_engine #(.NUM_LANE(4), .IN_WIDTH(8), .ACC_WIDTH(16), .AWIDTH(8), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i), .mode_i(mode_i), .sat_i(sat_i),
    .q_b0_i(q_a), .idle_o(idle_a), .read_o(read_a), .write_o(write_a), .done_o(done_a),
    .addr_b0_o(addr0_a), .ce_b0_o(ce0_a), .we_b0_o(we0_a), .d_b0_o(d0_a),
    .addr_b1_o(addr1_a), .ce_b1_o(ce1_a), .we_b1_o(we1_a), .d_b1_o(d1_a)
  );

  bram_acc_engine #(.NUM_LANE(4), .IN_WIDTH(8), .ACC_WIDTH(8), .AWIDTH(8), .CNT_WIDTH(8)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i), .mode_i(mode_i), .sat_i(sat_i),
    .q_b0_i(q_s), .idle_o(idle_s), .read_o(read_s), .write_o(write_s), .done_o(done_s),
    .addr_b0_o(addr0_s), .ce_b0_o(ce0_s), .we_b0_o(we0_s), .d_b0_o(d0_s),
    .addr_b1_o(addr1_s), .ce_b1_o(ce1_s), .we_b1_o(we1_s), .d_b1_o(d1_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_cfg(input int n, input logic [7:0] src, input logic [7:0] dst,
                           input logic mode, input logic sat);
    run_count_i = 8'(n);
    src_base_i  = src;
    dst_base_i  = dst;
    mode_i      = mode;
    sat_i       = sat;
  endtask

  // Runs one job and checks every cycle against the documented timeline:
  // reads in 1..N, writes in 3..N+2, done in N+3 (1 for N=0), idle after that.
  task automatic run(input string tag, input int n, input logic [7:0] src,
                     input logic [7:0] dst, input logic mode, input logic sat);
    int acc[4];
    int last_c;
    rd_log.delete(); wr_a_log.delete(); wr_d_log.delete(); wr_s_log.delete();
    for (int l = 0; l < 4; l++) acc[l] = 0;
    @(posedge clk); #1;
    drive_cfg(n, src, dst, mode, sat);
    start_run_i = 1'b1;
    @(posedge clk); #1;
    start_run_i = 1'b0;
    last_c = (n == 0) ? 2 : n + 4;
    for (int c = 1; c <= last_c; c++) begin
      logic        e_rd, e_wv, e_wr, e_done, e_idle;
      logic [7:0]  e_a1, e_a0;
      logic [63:0] e_d;
      int          kw;
      @(negedge clk);
      kw     = c - 3;
      e_rd   = (c >= 1) && (c <= n);
      e_wv   = (kw >= 0) && (kw < n);
      e_wr   = e_wv && (!mode || kw == n - 1);
      e_done = (n == 0) ? (c == 1) : (c == n + 3);
      e_idle = (c == last_c);
      if (e_wv) begin
        logic [31:0] row;
        row = mem[8'(src + 8'(kw))];
        for (int l = 0; l < 4; l++) begin
          acc[l] = acc[l] + int'(row[8*l +: 8]);
          if (sat && acc[l] > 65535) acc[l] = 65535;
          acc[l] = acc[l] & 32'hFFFF;
        end
      end
      e_d = '0;
      if (e_wr) for (int l = 0; l < 4; l++) e_d[16*l +: 16] = 16'(acc[l]);
      e_a1 = !e_wr ? 8'h00 : (mode ? dst : 8'(dst + 8'(kw)));
      e_a0 = src + 8'(c - 1);
      check($sformatf("%s_c%0d_status", tag, c),
            {56'd0, idle_a, read_a, write_a, done_a, ce0_a, ce1_a, we1_a, we0_a},
            {56'd0, e_idle, e_rd, e_wr, e_done, e_rd, e_wr, e_wr, 1'b0});
      if (e_rd) check($sformatf("%s_c%0d_addr0", tag, c), {56'd0, addr0_a}, {56'd0, e_a0});
      check($sformatf("%s_c%0d_addr1", tag, c), {56'd0, addr1_a}, {56'd0, e_a1});
      check($sformatf("%s_c%0d_d1", tag, c), d1_a, e_d);
      if (read_a) rd_log.push_back(addr0_a);
      if (write_a) begin
        wr_a_log.push_back(addr1_a);
        wr_d_log.push_back(d1_a);
      end
      if (write_s) wr_s_log.push_back(d1_s);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start_run_i = 1'b0;
    drive_cfg(0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      mem[i] = {b, b ^ 8'h5A, 8'(b * 8'd3), 8'hFF};
    end
    for (int i = 8'h10; i <= 8'h14; i++) mem[i] = 32'h01020304;
    for (int i = 8'h50; i <= 8'h52; i++) mem[i] = 32'h0A0A0A0A;
    for (int i = 8'h60; i <= 8'h62; i++) mem[i] = 32'h010101FF;
    mem[8'hFE] = 32'h11223344; mem[8'hFF] = 32'h55667788;
    mem[8'h00] = 32'h99AABBCC; mem[8'h01] = 32'hDDEEFF01;

    #12;
    check("rst_status", {56'd0, idle_a, read_a, write_a, done_a, ce0_a, ce1_a, we1_a, we0_a},
          {56'd0, 8'b1000_0000});
    check("rst_addr0", {56'd0, addr0_a}, 64'd0);
    check("rst_addr1", {56'd0, addr1_a}, 64'd0);
    check("rst_d1", d1_a, 64'd0);
    check("rst_d0", {32'd0, d0_a}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Abort a 5-row run during its third read, then rerun from clean state.
    @(posedge clk); #1;
    drive_cfg(5, 8'h10, 8'h20, 1'b0, 1'b0);
    start_run_i = 1'b1;
    @(posedge clk); #1;
    start_run_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_read_before", {63'd0, read_a}, 64'd1);
    check("mr_write_before", {63'd0, write_a}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mr_ce0", {63'd0, ce0_a}, 64'd0);
    check("mr_ce1", {63'd0, ce1_a}, 64'd0);
    check("mr_idle", {63'd0, idle_a}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    run("after_rst", 3, 8'h10, 8'h20, 1'b0, 1'b0);

    run("prefix", 4, 8'h10, 8'h20, 1'b0, 1'b0);
    check("prefix_nwr", 64'(wr_d_log.size()), 64'd4);
    check("prefix_w0", wr_d_log[0], 64'h0001_0002_0003_0004);
    check("prefix_w3", wr_d_log[3], 64'h0004_0008_000C_0010);
    check("prefix_a3", {56'd0, wr_a_log[3]}, 64'h23);

    run("total", 3, 8'h50, 8'h40, 1'b1, 1'b0);
    check("total_nwr", 64'(wr_d_log.size()), 64'd1);
    check("total_a", {56'd0, wr_a_log[0]}, 64'h40);
    check("total_d", wr_d_log[0], 64'h001E_001E_001E_001E);

    run("wrap", 4, 8'hFE, 8'hFF, 1'b0, 1'b0);
    check("wrap_r0", {56'd0, rd_log[0]}, 64'hFE);
    check("wrap_r1", {56'd0, rd_log[1]}, 64'hFF);
    check("wrap_r2", {56'd0, rd_log[2]}, 64'h00);
    check("wrap_r3", {56'd0, rd_log[3]}, 64'h01);
    check("wrap_w1", {56'd0, wr_a_log[1]}, 64'h00);

    run("sat1", 3, 8'h60, 8'h00, 1'b0, 1'b1);
    check("sat1_nwr", 64'(wr_s_log.size()), 64'd3);
    check("sat1_w0", {32'd0, wr_s_log[0]}, 64'h010101FF);
    check("sat1_w1", {32'd0, wr_s_log[1]}, 64'h020202FF);
    check("sat1_w2", {32'd0, wr_s_log[2]}, 64'h030303FF);

    run("sat0", 3, 8'h60, 8'h00, 1'b0, 1'b0);
    check("sat0_w0", {32'd0, wr_s_log[0]}, 64'h010101FF);
    check("sat0_w1", {32'd0, wr_s_log[1]}, 64'h020202FE);
    check("sat0_w2", {32'd0, wr_s_log[2]}, 64'h030303FD);

    run("n0", 0, 8'h10, 8'h20, 1'b0, 1'b0);
    check("n0_nrd", 64'(rd_log.size()), 64'd0);
    check("n0_nwr", 64'(wr_d_log.size()), 64'd0);

    // start held high: second run latches its new config at the idle cycle.
    @(posedge clk); #1;
    drive_cfg(2, 8'h10, 8'h20, 1'b0, 1'b0);
    start_run_i = 1'b1;
    @(posedge clk); #1;
    drive_cfg(1, 8'h50, 8'h70, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      logic        e_rd, e_wr, e_done, e_idle;
      logic [7:0]  e_a0, e_a1;
      logic [63:0] e_d;
      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_a0 = 8'h00; e_a1 = 8'h00; e_d = '0;
      e_done = (c == 5) || (c == 10);
      e_idle = (c == 6) || (c == 11);
      case (c)
        1: begin e_rd = 1'b1; e_a0 = 8'h10; end
        2: begin e_rd = 1'b1; e_a0 = 8'h11; end
        3: begin e_wr = 1'b1; e_a1 = 8'h20; e_d = 64'h0001_0002_0003_0004; end
        4: begin e_wr = 1'b1; e_a1 = 8'h21; e_d = 64'h0002_0004_0006_0008; end
        7: begin e_rd = 1'b1; e_a0 = 8'h50; end
        9: begin e_wr = 1'b1; e_a1 = 8'h70; e_d = 64'h000A_000A_000A_000A; end
        default: ;
      endcase
      check($sformatf("hold_c%0d_status", c), {60'd0, idle_a, read_a, write_a, done_a},
            {60'd0, e_idle, e_rd, e_wr, e_done});
      if (e_rd) check($sformatf("hold_c%0d_addr0", c), {56'd0, addr0_a}, {56'd0, e_a0});
      check($sformatf("hold_c%0d_addr1", c), {56'd0, addr1_a}, {56'd0, e_a1});
      check($sformatf("hold_c%0d_d1", c), d1_a, e_d);
      if (c == 8) start_run_i = 1'b0;
    end

    run("max", 255, 8'h00, 8'h80, 1'b0, 1'b1);
    check("max_nrd", 64'(rd_log.size()), 64'd255);
    check("max_nwr", 64'(wr_d_log.size()), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
